// File: rtl/gpio_link_pkg.sv
// gpio_link_pkg: shared FSM states, line levels and parity helper for the GPIO messenger link.
package gpio_link_pkg;
  typedef enum logic [2:0] {IDLE, PEND, START, DATA, PARITY, STOP} state_e;
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  function automatic logic even_parity(input logic [31:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/gpio_edge_detect.sv
// gpio_edge_detect: one-cycle tick on each rising edge of the same-domain gpio_clock.
module gpio_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic gpio_clock,
  output logic tick
);
  logic gpio_clock_q;
  // Resetting high keeps a gpio_clock that is already high at release from ticking.
  always_ff @(posedge clk) begin
    if (rst) gpio_clock_q <= 1'b1;
    else     gpio_clock_q <= gpio_clock;
  end
  assign tick = gpio_clock & ~gpio_clock_q;
endmodule

// File: rtl/gpio_serial_tx.sv
// gpio_serial_tx: LSB-first serial frame transmitter paced by gpio_clock ticks.
// Define GPIO_TX_PARITY_EN to insert an even-parity bit after the data bits.
module gpio_serial_tx
  import gpio_link_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 FPGA_clock,
  input  logic                 reset,
  input  logic                 gpio_clock,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 gpio_data_out,
  output logic                 busy,
  output logic                 frame_done
);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int SW = $clog2(STOP_BITS + 1);
`ifdef GPIO_TX_PARITY_EN
  localparam state_e AFTER_DATA = PARITY;
`else
  localparam state_e AFTER_DATA = STOP;
`endif
  state_e state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [SW-1:0] stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic line_q, line_d;
  logic tick, accept, bit_last, stop_last;
`ifdef GPIO_TX_PARITY_EN
  logic par_q, par_d;
`endif

  gpio_edge_detect u_edge (
    .clk        (FPGA_clock),
    .rst        (reset),
    .gpio_clock (gpio_clock),
    .tick       (tick)
  );

  assign tx_ready      = state_q == IDLE;
  assign busy          = ~tx_ready;
  assign accept        = tx_valid & tx_ready;
  assign bit_last      = bit_cnt_q == BW'(DATA_BITS - 1);
  assign stop_last     = stop_cnt_q == SW'(STOP_BITS - 1);
  assign gpio_data_out = line_q;

  always_ff @(posedge FPGA_clock) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      shift_q    <= '0;
      line_q     <= LINE_IDLE;
`ifdef GPIO_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      line_q     <= line_d;
`ifdef GPIO_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? PEND : IDLE;
      PEND:    state_d = tick ? START : PEND;
      START:   state_d = tick ? DATA : START;
      DATA:    state_d = (tick && bit_last) ? AFTER_DATA : DATA;
`ifdef GPIO_TX_PARITY_EN
      PARITY:  state_d = tick ? STOP : PARITY;
`endif
      STOP:    state_d = (tick && stop_last) ? IDLE : STOP;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    line_d     = line_q;
    frame_done = 1'b0;
`ifdef GPIO_TX_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      IDLE: begin
        shift_d = accept ? tx_data : shift_q;
`ifdef GPIO_TX_PARITY_EN
        par_d   = accept ? even_parity(32'(tx_data)) : par_q;
`endif
      end
      PEND: line_d = tick ? LINE_START : line_q;
      START: if (tick) begin
        line_d    = shift_q[0];
        shift_d   = shift_q >> 1;
        bit_cnt_d = '0;
      end
      DATA: if (tick) begin
        if (!bit_last) begin
          bit_cnt_d = bit_cnt_q + BW'(1);
          line_d    = shift_q[0];
          shift_d   = shift_q >> 1;
        end else begin
`ifdef GPIO_TX_PARITY_EN
          line_d = par_q;
`else
          line_d = LINE_IDLE;
`endif
          stop_cnt_d = '0;
        end
      end
`ifdef GPIO_TX_PARITY_EN
      PARITY: if (tick) begin
        line_d     = LINE_IDLE;
        stop_cnt_d = '0;
      end
`endif
      STOP: if (tick) begin
        stop_cnt_d = stop_last ? stop_cnt_q : stop_cnt_q + SW'(1);
        frame_done = stop_last;
      end
      default: ;
    endcase
  end
endmodule
